// File: rtl/divided_clock_period_meter.sv
// Measures period and high time of a slow periodic input in clock_in cycles,
// publishing each result with a strobe and flagging lock and input loss.
module divided_clock_period_meter #(
    parameter int unsigned COUNTER_RANGE = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic                     clock_in,
    input  logic                     nreset,
    input  logic                     signal_in,
    output logic [COUNTER_RANGE-1:0] period_out,
    output logic [COUNTER_RANGE-1:0] high_time_out,
    output logic                     measure_valid,
    output logic                     locked,
    output logic                     timeout
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [COUNTER_RANGE-1:0] CNT_MAX = '1;
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_PRE = MATCH_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0]   sync;
    logic                     s;
    logic                     s_prev;
    logic                     rise;
    logic                     fall;
    logic [COUNTER_RANGE-1:0] cnt;
    logic [COUNTER_RANGE-1:0] high_cnt;
    logic [MATCH_W-1:0]       match_cnt;
    logic                     load_cnt;
    logic                     latch_high;
    logic                     publish;
    logic                     expire;
    logic                     cnt_full;
    logic                     same_pair;

    assign s         = sync[SYNC_STAGES-1];
    assign cnt_full  = (cnt == CNT_MAX);
    assign same_pair = (cnt == period_out) && (high_cnt == high_time_out);

    // Synchronizer plus registered edge flags
    always_ff @(posedge clock_in) begin
        if (!nreset) begin
            sync   <= '0;
            s_prev <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], signal_in};
            s_prev <= s;
            rise   <= s & ~s_prev;
            fall   <= ~s & s_prev;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_cnt   = 1'b0;
        latch_high = 1'b0;
        publish    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    load_cnt   = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    latch_high = 1'b1;
                    state_next = LOW;
                end else if (cnt_full) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    publish    = 1'b1;
                    load_cnt   = 1'b1;
                    state_next = HIGH;
                end else if (cnt_full) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating measurement counter; saturation is the loss-of-input condition
    always_ff @(posedge clock_in) begin
        if (!nreset) begin
            cnt      <= '0;
            high_cnt <= '0;
        end else begin
            if (load_cnt) begin
                cnt <= COUNTER_RANGE'(1);
            end else if (expire) begin
                cnt <= '0;
            end else if (state != IDLE && !cnt_full) begin
                cnt <= cnt + COUNTER_RANGE'(1);
            end
            if (latch_high) begin
                high_cnt <= cnt;
            end
        end
    end

    // Publication, lock tracking and sticky timeout
    always_ff @(posedge clock_in) begin
        if (!nreset) begin
            period_out    <= '0;
            high_time_out <= '0;
            measure_valid <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b0;
            match_cnt     <= '0;
        end else begin
            measure_valid <= publish;
            if (publish) begin
                period_out    <= cnt;
                high_time_out <= high_cnt;
                timeout       <= 1'b0;
                if (match_cnt == '0 || !same_pair) begin
                    match_cnt <= MATCH_W'(1);
                    locked    <= 1'b0;
                end else begin
                    if (match_cnt != MATCH_MAX) begin
                        match_cnt <= match_cnt + MATCH_W'(1);
                    end
                    locked <= (match_cnt >= MATCH_PRE);
                end
            end else if (expire) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_divided_clock_period_meter.sv
// Directed bench for divided_clock_period_meter with an 8-bit counter so the
// timeout path is reachable in a few hundred cycles.
module tb_divided_clock_period_meter;

    localparam int unsigned CR = 8;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          signal_in = 1'b0;
    logic [CR-1:0] period_out;
    logic [CR-1:0] high_time_out;
    logic          measure_valid;
    logic          locked;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int p;
        int h;
        int lk;
        int to;
    } meas_t;

    meas_t mq[$];

    divided_clock_period_meter #(
        .COUNTER_RANGE(CR),
        .SYNC_STAGES  (2),
        .LOCK_COUNT   (4)
    ) dut (
        .clock_in     (clk),
        .nreset       (nreset),
        .signal_in    (signal_in),
        .period_out   (period_out),
        .high_time_out(high_time_out),
        .measure_valid(measure_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // One clock_in cycle: sample outputs of the previous edge, then drive signal_in
    task automatic tick(input logic v);
        meas_t m;
        @(negedge clk);
        if (measure_valid === 1'b1) begin
            m.p  = int'(period_out);
            m.h  = int'(high_time_out);
            m.lk = int'(locked);
            m.to = int'(timeout);
            mq.push_back(m);
        end
        signal_in = v;
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) tick(1'b1);
            repeat (l) tick(1'b0);
        end
    endtask

    // Final rise closes the last period, then idle long enough to see the strobe
    task automatic flush_rise();
        tick(1'b1);
        repeat (8) tick(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset    = 1'b0;
        signal_in = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        mq.delete();
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        signal_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (period_out !== 8'd0 || high_time_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_values period=%0d high=%0d expected 0/0", period_out, high_time_out);
        end
        checks++;
        if (measure_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags mv=%b locked=%b timeout=%b expected 0/0/0",
                     measure_valid, locked, timeout);
        end
        nreset = 1'b1;
    endtask

    task automatic test_min_period();
        do_reset();
        wave(1, 1, 6);
        flush_rise();
        checks++;
        if (mq.size() !== 6) begin
            errors++;
            $display("FAIL min_count got %0d expected 6", mq.size());
        end
        for (int i = 0; i < mq.size() && i < 6; i++) begin
            checks++;
            if (mq[i].p !== 2 || mq[i].h !== 1 || mq[i].lk !== ((i >= 3) ? 1 : 0) || mq[i].to !== 0) begin
                errors++;
                $display("FAIL min_meas%0d got %0d/%0d lk=%0d to=%0d expected 2/1 lk=%0d to=0",
                         i, mq[i].p, mq[i].h, mq[i].lk, mq[i].to, (i >= 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_divisor_switch();
        int ep;
        int eh;
        do_reset();
        wave(3, 3, 5);
        wave(5, 5, 5);
        flush_rise();
        checks++;
        if (mq.size() !== 10) begin
            errors++;
            $display("FAIL switch_count got %0d expected 10", mq.size());
        end
        for (int i = 0; i < mq.size() && i < 10; i++) begin
            ep = (i < 5) ? 6 : 10;
            eh = (i < 5) ? 3 : 5;
            checks++;
            if (mq[i].p !== ep || mq[i].h !== eh || mq[i].lk !== (((i % 5) >= 3) ? 1 : 0)) begin
                errors++;
                $display("FAIL switch_meas%0d got %0d/%0d lk=%0d expected %0d/%0d lk=%0d",
                         i, mq[i].p, mq[i].h, mq[i].lk, ep, eh, ((i % 5) >= 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_asymmetric();
        do_reset();
        wave(2, 5, 5);
        flush_rise();
        checks++;
        if (mq.size() !== 5) begin
            errors++;
            $display("FAIL asym_count got %0d expected 5", mq.size());
        end
        for (int i = 0; i < mq.size() && i < 5; i++) begin
            checks++;
            if (mq[i].p !== 7 || mq[i].h !== 2 || mq[i].lk !== ((i >= 3) ? 1 : 0)) begin
                errors++;
                $display("FAIL asym_meas%0d got %0d/%0d lk=%0d expected 7/2 lk=%0d",
                         i, mq[i].p, mq[i].h, mq[i].lk, (i >= 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_timeout();
        int first_to = 0;
        do_reset();
        wave(2, 2, 5);
        tick(1'b1);
        for (int k = 1; k <= 300; k++) begin
            tick(1'b1);
            if (timeout === 1'b1 && first_to == 0) first_to = k;
        end
        // cnt=1 at edge 4 after the drive, all-ones at edge 258, timeout at 259
        checks++;
        if (first_to !== 259) begin
            errors++;
            $display("FAIL timeout_cycle got %0d expected 259", first_to);
        end
        checks++;
        if (mq.size() !== 5 || (mq.size() == 5 && mq[4].lk !== 1)) begin
            errors++;
            $display("FAIL timeout_pre_meas count=%0d expected 5 with last locked", mq.size());
        end
        checks++;
        if (locked !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags locked=%b timeout=%b expected 0/1", locked, timeout);
        end
        checks++;
        if (period_out !== 8'd4 || high_time_out !== 8'd2) begin
            errors++;
            $display("FAIL timeout_hold got %0d/%0d expected 4/2", period_out, high_time_out);
        end
        mq.delete();
        repeat (4) tick(1'b0);
        wave(4, 4, 3);
        flush_rise();
        checks++;
        if (mq.size() !== 3) begin
            errors++;
            $display("FAIL resume_count got %0d expected 3", mq.size());
        end
        if (mq.size() > 0) begin
            checks++;
            if (mq[0].p !== 8 || mq[0].h !== 4 || mq[0].to !== 0 || mq[0].lk !== 0) begin
                errors++;
                $display("FAIL resume_first got %0d/%0d to=%0d lk=%0d expected 8/4 to=0 lk=0",
                         mq[0].p, mq[0].h, mq[0].to, mq[0].lk);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        do_reset();
        wave(4, 4, 3);
        repeat (6) tick(1'b1);
        @(negedge clk);
        nreset    = 1'b0;
        signal_in = 1'b0;
        @(negedge clk);
        checks++;
        if (period_out !== 8'd0 || high_time_out !== 8'd0 || measure_valid !== 1'b0 ||
            locked !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs p=%0d h=%0d mv=%b lk=%b to=%b expected all 0",
                     period_out, high_time_out, measure_valid, locked, timeout);
        end
        nreset = 1'b1;
        mq.delete();
        repeat (4) tick(1'b0);
        wave(4, 4, 2);
        flush_rise();
        checks++;
        if (mq.size() !== 2) begin
            errors++;
            $display("FAIL midreset_count got %0d expected 2", mq.size());
        end
        for (int i = 0; i < mq.size() && i < 2; i++) begin
            checks++;
            if (mq[i].p !== 8 || mq[i].h !== 4 || mq[i].lk !== 0) begin
                errors++;
                $display("FAIL midreset_meas%0d got %0d/%0d lk=%0d expected 8/4 lk=0",
                         i, mq[i].p, mq[i].h, mq[i].lk);
            end
        end
    endtask

    task automatic test_latency();
        int seen = 0;
        do_reset();
        wave(3, 3, 2);
        mq.delete();
        tick(1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            if (mq.size() > 0 && seen == 0) seen = k;
        end
        checks++;
        if (seen !== 4) begin
            errors++;
            $display("FAIL latency got %0d expected 4", seen);
        end
        checks++;
        if (mq.size() !== 1 || (mq.size() == 1 && (mq[0].p !== 6 || mq[0].h !== 3))) begin
            errors++;
            $display("FAIL latency_meas count=%0d expected one 6/3", mq.size());
        end
    endtask

    initial begin
        test_reset();
        test_min_period();
        test_divisor_switch();
        test_asymmetric();
        test_timeout();
        test_reset_mid_high();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
